// File: rtl/square_reg_recv.sv
// Square-channel register write receiver: buffers up to two CPU writes to $4000-$4003
// and retires one per ACLK tick, updating the decoded fields and pulsing WR0..WR3.
module square_reg_recv (
  input  logic        CLK,
  input  logic        n_RES,
  input  logic        aclk_tick,
  input  logic        wr_en,
  input  logic [1:0]  addr,
  input  logic [7:0]  DB,
  input  logic        ovf_clr,
  output logic        WR0,
  output logic        WR1,
  output logic        WR2,
  output logic        WR3,
  output logic [1:0]  duty,
  output logic        lc_halt,
  output logic        const_vol,
  output logic [3:0]  vol,
  output logic [7:0]  sweep,
  output logic [10:0] period,
  output logic [4:0]  lc_index,
  output logic [1:0]  pending,
  output logic        overflow
);

  typedef struct packed {
    logic [1:0] a;
    logic [7:0] d;
  } entry_t;

  entry_t      q0_q, q0_d;
  entry_t      q1_q, q1_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        ovf_q, ovf_d;
  logic [3:0]  wr_q, wr_d;
  logic [7:0]  r4000_q, r4000_d;
  logic [7:0]  sweep_q, sweep_d;
  logic [10:0] period_q, period_d;
  logic [4:0]  lc_idx_q, lc_idx_d;

  logic        pop, push, drop;
  logic [1:0]  base;
  entry_t      new_e;

  always_comb begin
    // Pop only drains entries present before this edge, so a same-edge push never pops.
    pop   = aclk_tick && (cnt_q != 2'd0);
    push  = wr_en && ((cnt_q != 2'd2) || pop);
    drop  = wr_en && (cnt_q == 2'd2) && !pop;
    base  = cnt_q - {1'b0, pop};
    new_e = '{a: addr, d: DB};

    q0_d     = q0_q;
    q1_d     = q1_q;
    cnt_d    = base + {1'b0, push};
    wr_d     = 4'b0000;
    r4000_d  = r4000_q;
    sweep_d  = sweep_q;
    period_d = period_q;
    lc_idx_d = lc_idx_q;

    if (pop) q0_d = q1_q;
    if (push) begin
      if (base == 2'd0) q0_d = new_e;
      else              q1_d = new_e;
    end

    if (pop) begin
      wr_d[q0_q.a] = 1'b1;
      case (q0_q.a)
        2'd0: r4000_d = q0_q.d;
        2'd1: sweep_d = q0_q.d;
        2'd2: period_d[7:0] = q0_q.d;
        default: begin
          period_d[10:8] = q0_q.d[2:0];
          lc_idx_d       = q0_q.d[7:3];
        end
      endcase
    end

    // A drop in the same cycle as a clear leaves the flag set.
    ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
  end

  always_ff @(posedge CLK or negedge n_RES) begin
    if (!n_RES) begin
      cnt_q    <= 2'd0;
      ovf_q    <= 1'b0;
      wr_q     <= 4'b0000;
      r4000_q  <= 8'h00;
      sweep_q  <= 8'h00;
      period_q <= 11'h000;
      lc_idx_q <= 5'h00;
    end else begin
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      wr_q     <= wr_d;
      r4000_q  <= r4000_d;
      sweep_q  <= sweep_d;
      period_q <= period_d;
      lc_idx_q <= lc_idx_d;
    end
  end

  // Slot contents are only meaningful below cnt_q, so they need no reset.
  always_ff @(posedge CLK) begin
    q0_q <= q0_d;
    q1_q <= q1_d;
  end

  assign {WR3, WR2, WR1, WR0} = wr_q;
  assign duty      = r4000_q[7:6];
  assign lc_halt   = r4000_q[5];
  assign const_vol = r4000_q[4];
  assign vol       = r4000_q[3:0];
  assign sweep     = sweep_q;
  assign period    = period_q;
  assign lc_index  = lc_idx_q;
  assign pending   = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_square_reg_recv.sv
// Randomised and directed bench for square_reg_recv with a queue-based register-image model
// and a strobe scoreboard checked by an independent monitor.
module tb_square_reg_recv;

  logic        CLK = 1'b0;
  logic        n_RES = 1'b0;
  logic        aclk_tick = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [7:0]  DB = 8'h00;
  logic        ovf_clr = 1'b0;
  logic        WR0, WR1, WR2, WR3;
  logic [1:0]  duty;
  logic        lc_halt, const_vol;
  logic [3:0]  vol;
  logic [7:0]  sweep;
  logic [10:0] period;
  logic [4:0]  lc_index;
  logic [1:0]  pending;
  logic        overflow;

  square_reg_recv dut (
    .CLK(CLK), .n_RES(n_RES), .aclk_tick(aclk_tick), .wr_en(wr_en), .addr(addr),
    .DB(DB), .ovf_clr(ovf_clr), .WR0(WR0), .WR1(WR1), .WR2(WR2), .WR3(WR3),
    .duty(duty), .lc_halt(lc_halt), .const_vol(const_vol), .vol(vol), .sweep(sweep),
    .period(period), .lc_index(lc_index), .pending(pending), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] a;
    logic [7:0] d;
  } wr_t;
  typedef struct {
    logic [1:0] a;
    int         cyc;
  } strobe_t;

  wr_t        mq[$];
  strobe_t    sb[$];
  logic [7:0] img[4];
  logic       m_ovf;
  int         cyc;
  int         tests;
  int         fails;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    sb.delete();
    for (int i = 0; i < 4; i++) img[i] = 8'h00;
    m_ovf = 1'b0;
  endtask

  // Register images: each write replaces a whole byte; outputs are slices of the images.
  task automatic model_edge(input logic w, input logic [1:0] a, input logic [7:0] d,
                            input logic t, input logic c);
    wr_t     e;
    strobe_t s;
    if (t && mq.size() > 0) begin
      e = mq.pop_front();
      img[e.a] = e.d;
      s.a = e.a;
      s.cyc = cyc;
      sb.push_back(s);
    end
    if (c) m_ovf = 1'b0;
    if (w) begin
      if (mq.size() < 2) begin
        e.a = a;
        e.d = d;
        mq.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic step(input logic w, input logic [1:0] a, input logic [7:0] d,
                      input logic t, input logic c);
    wr_en = w; addr = a; DB = d; aclk_tick = t; ovf_clr = c;
    @(posedge CLK);
    cyc++;
    if (n_RES) model_edge(w, a, d, t, c);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
  endtask

  // Monitor: compares every cycle on the falling edge, away from the sampling edge.
  always begin
    logic [3:0] exp_wr;
    strobe_t    s;
    @(negedge CLK);
    exp_wr = 4'b0000;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      s = sb.pop_front();
      exp_wr[s.a] = 1'b1;
    end
    chk("strobe", {28'd0, WR3, WR2, WR1, WR0}, {28'd0, exp_wr});
    chk("fields", {duty, lc_halt, const_vol, vol, sweep, period, lc_index},
        {img[0], img[1], img[3][2:0], img[2], img[3][7:3]});
    chk("pending", {30'd0, pending}, 32'(mq.size()));
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
  end

  initial begin
    tests = 0;
    fails = 0;
    cyc = 0;
    model_clear();

    // Reset held with busy inputs
    n_RES = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 2'd3, 8'hFF, 1'b1, 1'b0);
    n_RES = 1'b1;
    idle(2);

    // Single write, tick three edges later
    step(1'b1, 2'd0, 8'h9F, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Period split over $4002/$4003
    step(1'b1, 2'd2, 8'hA5, 1'b0, 1'b0);
    step(1'b1, 2'd3, 8'hFB, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Overflow on third write, then drain and clear
    step(1'b1, 2'd1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 2'd1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 2'd1, 8'h33, 1'b0, 1'b0);
    idle(1);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
    idle(1);

    // Drop and clear in the same cycle: set wins
    step(1'b1, 2'd0, 8'h12, 1'b0, 1'b0);
    step(1'b1, 2'd1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'h56, 1'b0, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);

    // Simultaneous push and pop at full, then drain back-to-back
    step(1'b1, 2'd2, 8'h78, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Simultaneous push and pop with one entry, and push into empty with tick
    step(1'b1, 2'd3, 8'h0C, 1'b1, 1'b0);
    step(1'b1, 2'd0, 8'hE1, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(1);

    // Reset mid-queue between ticks
    step(1'b1, 2'd1, 8'hAA, 1'b0, 1'b0);
    step(1'b1, 2'd2, 8'hBB, 1'b0, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b1, 2'd3, 8'hCC, 1'b0, 1'b0);
    n_RES = 1'b0;
    model_clear();
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    n_RES = 1'b1;
    step(1'b1, 2'd1, 8'h5A, 1'b1, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) < 55) ? 1'b1 : 1'b0,
           2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)),
           ($urandom_range(0, 99) < 40) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 8) ? 1'b1 : 1'b0);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0);
    idle(2);

    chk("leftover_strobes", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/square_reg_recv.md
# square_reg_recv

Receiving end of the square-channel register write path. It captures CPU-side writes to the four square-channel registers ($4000–$4003), stores up to two pending writes, and drains them one per ACLK tick. On each drain it updates the decoded register fields and pulses the matching WR0..WR3 strobe for one cycle. It sits between the CPU bus interface and the SQUARE_Duty, sweep, envelope and length units, which consume the strobes and fields.

## Interface
Parameters: none (fixed 2-entry queue, fixed square-channel register map).

- CLK  in  1  core clock; all state updates on posedge
- n_RES  in  1  asynchronous reset, active low; clears all state immediately
- aclk_tick  in  1  one-CLK pulse marking the ACLK edge; drain point
- wr_en  in  1  bus write request; sampled at posedge
- addr  in  2  register select (0..3 = $4000..$4003)
- DB  in  8  write data, sampled with wr_en
- ovf_clr  in  1  clears sticky overflow flag
- WR0, WR1, WR2, WR3  out  1 each  one-CLK write strobes, asserted after a drain
- duty  out  2  $4000[7:6]
- lc_halt  out  1  $4000[5]
- const_vol  out  1  $4000[4]
- vol  out  4  $4000[3:0]
- sweep  out  8  $4001 raw
- period  out  11  {$4003[2:0], $4002[7:0]}
- lc_index  out  5  $4003[7:3]
- pending  out  2  queue occupancy (0..2)
- overflow  out  1  sticky; set when a write is dropped

## Operation
- Queue: 2-entry FIFO of {addr, DB}. Push at a posedge with wr_en=1. Pop at a posedge with aclk_tick=1 when pending≠0 before that edge.
- An entry pushed at edge k cannot pop at edge k. Minimum residency is one edge.
- Drain at edge k: the field named by the popped addr updates at edge k. WRn for that addr is high for exactly the cycle following edge k; all other WRx stay low. Only one WRx is ever high at a time.
- Field updates:
  - addr 0 loads duty, lc_halt, const_vol, vol.
  - addr 1 loads sweep.
  - addr 2 loads period[7:0] only.
  - addr 3 loads period[10:8] from DB[2:0] and lc_index from DB[7:3].
  - Unaffected bits hold their values.
- Simultaneous push and pop:
  - pending 0: the push is accepted; no pop occurs (the queue was empty before the edge); pending becomes 1.
  - pending 1: the head pops, the new entry becomes the head; pending stays 1.
  - pending 2: the pop frees a slot, the push is accepted; pending stays 2; overflow is not set.
- Full: push with pending=2 and no pop drops the write. Queue contents are unchanged and overflow becomes 1.
- overflow clears at a posedge with ovf_clr=1. If a drop and ovf_clr occur in the same cycle, the set wins (overflow=1).
- FIFO order is strict: writes drain in arrival order, including repeated writes to the same addr.
- Reset mid-operation: n_RES low empties the queue (pending=0) and discards queued entries, with no strobes. All fields, strobes and overflow go to 0 asynchronously.

## Timing
- Reset values: duty=0, lc_halt=0, const_vol=0, vol=0, sweep=8'h00, period=11'h000, lc_index=0, WR0..WR3=0, pending=0, overflow=0.
- All outputs are registered, with no combinational path from inputs to outputs.
- Latency from write to field: with an empty queue, push at edge k, then the first aclk_tick edge at k+1 or later updates the field at that edge. The WRn strobe is high for the following cycle.
- The strobe is high for exactly one CLK regardless of aclk_tick spacing. Back-to-back aclk_tick edges with pending=2 give WRa then WRb in consecutive cycles.
- pending updates at the same edge as push/pop.
- Field updates and the WRn rising edge are aligned to the same posedge.
- After n_RES deasserts, the first push is honoured at the first posedge.

## Test plan
- Reset: hold n_RES=0, drive wr_en/aclk_tick/DB=8'hFF -> all outputs 0, pending=0; release, no strobes until a write.
- Single write: addr=0, DB=8'h9F at edge 5, aclk_tick at edge 8 -> duty=2, lc_halt=0, const_vol=1, vol=4'hF from edge 8; WR0 high for exactly one cycle; pending 1→0.
- Period split: write addr=2 DB=8'hA5, then addr=3 DB=8'hFB, two ticks -> period=11'h3A5, lc_index=5'h1F; WR2 then WR3 on separate cycles, in order.
- Overflow: three writes (addr 1, DB=11,22,33) with no tick -> pending=2, overflow=1; two ticks -> sweep=8'h11 then 8'h22; 33 never appears; ovf_clr -> overflow=0.
- Simultaneous push/pop at full: pending=2, wr_en and aclk_tick at the same edge -> pending stays 2, overflow stays 0, head strobe fires.
- Reset mid-queue: pending=2, assert n_RES low between ticks -> pending=0, no WRx ever fires for the discarded entries, fields=0.
